ncc_window_feeder: RTL and testbench



---
 rtl/ncc_pkg.sv | 29 ++
 rtl/ncc_pix_log2_enc.sv | 28 ++
 rtl/ncc_window_feeder.sv | 176 +++++++++++++++++
 tb/tb_ncc_window_feeder.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncc_pkg.sv
// Shared types for the NCC window path: log2 word layout, feeder FSM states
// and the lane extraction helper for packed pixel words.
package ncc_pkg;

  localparam int PIX_W      = 8;
  localparam int LOG_INT_W  = 5;
  localparam int LOG_FRAC_W = 27;
  localparam int LOG_W      = 1 + LOG_INT_W + LOG_FRAC_W;

  typedef struct packed {
    logic                  sign;
    logic [LOG_INT_W-1:0]  int_val;
    logic [LOG_FRAC_W-1:0] frac;
  } log_word_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EMIT,
    FLUSH,
    DONE
  } feeder_state_t;

  // Lane 0 sits in the most significant byte of the word.
  function automatic logic [PIX_W-1:0] lane_pix(input logic [31:0] word, input logic [1:0] lane);
    return word[PIX_W*(3-int'(lane)) +: PIX_W];
  endfunction

endpackage

// File: rtl/ncc_pix_log2_enc.sv
// Combinational log2 packer: leading-one position becomes the integer field,
// the bits below it are left-justified into the fraction.
module ncc_pix_log2_enc
  import ncc_pkg::*;
(
  input  logic             sign,
  input  logic [PIX_W-1:0] mag,
  output log_word_t        word
);

  localparam int LEAD_W = $clog2(PIX_W);

  logic [PIX_W-1:0]  mag_c;
  logic [LEAD_W-1:0] lead;

  always_comb begin
    mag_c = (mag == '0) ? PIX_W'(1) : mag;
    lead  = '0;
    for (int i = 0; i < PIX_W; i++) begin
      if (mag_c[i]) lead = LEAD_W'(i);
    end
    word.sign    = sign;
    word.int_val = LOG_INT_W'(lead);
    // The leading one itself is shifted out past the top of the fraction.
    word.frac    = LOG_FRAC_W'(mag_c) << (LOG_FRAC_W - int'(lead));
  end

endmodule

// File: rtl/ncc_window_feeder.sv
// Streams packed pixels into the PE chain as log2 words, one per cycle, then
// flushes the chain and pulses row_done. Optional mean subtraction: NCC_FEEDER_MEAN_SUB_EN.
module ncc_window_feeder
  import ncc_pkg::*;
#(
  parameter int WIN_WIDTH    = 640,
  parameter int DESC_DIM     = 16,
  parameter int PIX_PER_WORD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             row_start,
  input  logic [31:0]      pix_word_in,
  input  logic             pix_valid,
`ifdef NCC_FEEDER_MEAN_SUB_EN
  input  logic [PIX_W-1:0] mean_in,
`endif
  output logic             pix_ready,
  output logic [LOG_W-1:0] window_out,
  output logic             load_win_reg,
  output logic             load_acc_sum_reg,
  output logic             row_done,
  output logic             busy
);

  localparam int WORDS  = WIN_WIDTH / PIX_PER_WORD;
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int FCNT_W = (DESC_DIM > 2) ? $clog2(DESC_DIM - 1) : 1;

  if (WIN_WIDTH % PIX_PER_WORD != 0) begin : g_bad_width
    $error("WIN_WIDTH must be a multiple of PIX_PER_WORD");
  end
  if (PIX_PER_WORD != 4) begin : g_bad_ppw
    $error("PIX_PER_WORD is fixed at 4");
  end
  if (DESC_DIM < 2) begin : g_bad_dim
    $error("DESC_DIM must be at least 2");
  end

  feeder_state_t     state, state_nxt;
  logic [WCNT_W-1:0] word_cnt, word_cnt_nxt;
  logic [FCNT_W-1:0] flush_cnt, flush_nxt;
  logic [1:0]        lane, lane_nxt;
  logic [31:0]       word_reg, word_nxt;
  logic [LOG_W-1:0]  win_nxt;
  logic              load_nxt, done_nxt;
  logic              xfer, last_word;
  logic [PIX_W-1:0]  enc_pix, enc_mag;
  logic              enc_sign;
  log_word_t         enc_word;

  assign last_word = (word_cnt == WCNT_W'(WORDS - 1));
  assign pix_ready = !rst && ((state == FETCH) ||
                              (state == EMIT && lane == 2'd3 && !last_word));
  assign xfer      = pix_valid && pix_ready;
  assign busy      = (state != IDLE);
  assign load_acc_sum_reg = load_win_reg;

  // A freshly accepted word feeds its lane 0 straight into the encoder so the
  // first pixel appears the cycle after the handshake.
  assign enc_pix = xfer ? lane_pix(pix_word_in, 2'd0) : lane_pix(word_reg, 2'(lane + 2'd1));

`ifdef NCC_FEEDER_MEAN_SUB_EN
  logic [PIX_W-1:0] mean_reg, mean_nxt;
  logic [PIX_W:0]   diff;

  assign diff     = {1'b0, enc_pix} - {1'b0, mean_reg};
  assign enc_sign = diff[PIX_W];
  assign enc_mag  = diff[PIX_W] ? PIX_W'(-diff) : diff[PIX_W-1:0];
`else
  assign enc_sign = 1'b0;
  assign enc_mag  = enc_pix;
`endif

  ncc_pix_log2_enc u_enc (
    .sign (enc_sign),
    .mag  (enc_mag),
    .word (enc_word)
  );

  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    flush_nxt    = flush_cnt;
    lane_nxt     = lane;
    word_nxt     = word_reg;
    win_nxt      = window_out;
    load_nxt     = 1'b0;
    done_nxt     = 1'b0;
`ifdef NCC_FEEDER_MEAN_SUB_EN
    mean_nxt     = mean_reg;
`endif
    case (state)
      IDLE: begin
        if (row_start) begin
          word_cnt_nxt = '0;
          state_nxt    = FETCH;
`ifdef NCC_FEEDER_MEAN_SUB_EN
          mean_nxt     = mean_in;
`endif
        end
      end
      FETCH: begin
        if (xfer) begin
          word_nxt  = pix_word_in;
          lane_nxt  = 2'd0;
          win_nxt   = enc_word;
          load_nxt  = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (lane != 2'd3) begin
          lane_nxt = 2'(lane + 2'd1);
          win_nxt  = enc_word;
          load_nxt = 1'b1;
        end else if (last_word) begin
          flush_nxt = '0;
          win_nxt   = '0;
          load_nxt  = 1'b1;
          state_nxt = FLUSH;
        end else begin
          word_cnt_nxt = word_cnt + 1'b1;
          if (xfer) begin
            word_nxt = pix_word_in;
            lane_nxt = 2'd0;
            win_nxt  = enc_word;
            load_nxt = 1'b1;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt == FCNT_W'(DESC_DIM - 2)) begin
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else begin
          flush_nxt = flush_cnt + 1'b1;
          load_nxt  = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      word_cnt     <= '0;
      flush_cnt    <= '0;
      lane         <= '0;
      word_reg     <= '0;
      window_out   <= '0;
      load_win_reg <= 1'b0;
      row_done     <= 1'b0;
`ifdef NCC_FEEDER_MEAN_SUB_EN
      mean_reg     <= '0;
`endif
    end else begin
      state        <= state_nxt;
      word_cnt     <= word_cnt_nxt;
      flush_cnt    <= flush_nxt;
      lane         <= lane_nxt;
      word_reg     <= word_nxt;
      window_out   <= win_nxt;
      load_win_reg <= load_nxt;
      row_done     <= done_nxt;
`ifdef NCC_FEEDER_MEAN_SUB_EN
      mean_reg     <= mean_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ncc_window_feeder.sv
// Self-checking bench for ncc_window_feeder: table rows, randomized rows with
// stalls, row_start glitch, reset during flush, and mean subtraction when enabled.
module tb_ncc_window_feeder;

  localparam int WIN_WIDTH = 8;
  localparam int DESC_DIM  = 4;
  localparam int WPR       = WIN_WIDTH / 4;

  logic        clk;
  logic        rst;
  logic        row_start;
  logic [31:0] pix_word_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [32:0] window_out;
  logic        load_win_reg;
  logic        load_acc_sum_reg;
  logic        row_done;
  logic        busy;
`ifdef NCC_FEEDER_MEAN_SUB_EN
  logic [7:0]  mean_in;
`endif

  ncc_window_feeder #(
    .WIN_WIDTH    (WIN_WIDTH),
    .DESC_DIM     (DESC_DIM),
    .PIX_PER_WORD (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .row_start        (row_start),
    .pix_word_in      (pix_word_in),
    .pix_valid        (pix_valid),
`ifdef NCC_FEEDER_MEAN_SUB_EN
    .mean_in          (mean_in),
`endif
    .pix_ready        (pix_ready),
    .window_out       (window_out),
    .load_win_reg     (load_win_reg),
    .load_acc_sum_reg (load_acc_sum_reg),
    .row_done         (row_done),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      word;
    logic [3:0][32:0] exp;
  } vec_t;

  int               checks = 0;
  int               errors = 0;
  logic [32:0]      exp_q[$];
  int               gaps[$];
  logic [3:0][32:0] cur_exp;
  logic [31:0]      row_words[WPR];
  logic [3:0][32:0] row_exps[WPR];
  vec_t             vecs[4];
  int               words_in_row, must_strobe, cur_run, max_run, gap_cnt, row_strobes, rows_done;
  logic [32:0]      last_win;
  logic             prev_load;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoding from the arithmetic definition of the log2 format.
  function automatic logic [32:0] model_enc(input int p, input int mean);
    int   d, mag, k, frac;
    logic s;
    d   = p - mean;
    s   = (d < 0);
    mag = s ? -d : d;
    if (mag == 0) mag = 1;
    k = 0;
    while ((2 ** (k + 1)) <= mag) k++;
    frac = (mag - 2 ** k) * (2 ** (27 - k));
    return {s, k[4:0], frac[26:0]};
  endfunction

  function automatic logic [3:0][32:0] model_word(input logic [31:0] w, input int mean);
    logic [3:0][32:0] e;
    for (int l = 0; l < 4; l++) e[l] = model_enc(int'(w[31-8*l -: 8]), mean);
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic [31:0] w, input logic [32:0] e0, input logic [32:0] e1,
                                  input logic [32:0] e2, input logic [32:0] e3);
    vec_t v;
    v.word   = w;
    v.exp[0] = e0;
    v.exp[1] = e1;
    v.exp[2] = e2;
    v.exp[3] = e3;
    return v;
  endfunction

  // Scoreboard: every accepted word queues four pixels, every completed row
  // queues DESC_DIM-1 flush zeros; strobed cycles pop in order.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      words_in_row = 0;
      must_strobe  = 0;
      last_win     = '0;
      prev_load    = 1'b0;
      cur_run      = 0;
      gap_cnt      = 0;
      row_strobes  = 0;
    end else begin
      if (must_strobe > 0) begin
        check_output("lane_latency", load_win_reg, 1);
        must_strobe--;
      end
      if (load_win_reg) begin
        check_output("acc_strobe", load_acc_sum_reg, 1);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL extra_strobe: got strobe with window_out 0x%0h, required no strobe", window_out);
        end else begin
          checks--;
          check_output("window_out", window_out, exp_q.pop_front());
        end
        if (!prev_load && row_strobes > 0) gaps.push_back(gap_cnt);
        gap_cnt  = 0;
        row_strobes++;
        cur_run++;
        last_win = window_out;
      end else begin
        check_output("hold", window_out, last_win);
        check_output("acc_strobe", load_acc_sum_reg, 0);
        if (cur_run > max_run) max_run = cur_run;
        cur_run = 0;
        if (row_strobes > 0) gap_cnt++;
      end
      if (row_done) begin
        check_output("row_done_pending", exp_q.size(), 0);
        check_output("row_done_after_flush", prev_load, 1);
        rows_done++;
        row_strobes = 0;
        gap_cnt     = 0;
      end
      if (pix_valid && pix_ready) begin
        for (int l = 0; l < 4; l++) exp_q.push_back(cur_exp[l]);
        must_strobe = 4;
        words_in_row++;
        if (words_in_row == WPR) begin
          for (int f = 0; f < DESC_DIM - 1; f++) exp_q.push_back('0);
          words_in_row = 0;
        end
      end
      prev_load = load_win_reg;
    end
  end

  task automatic apply_stimulus(input logic [31:0] word, input logic [3:0][32:0] exps);
    int n;
    cur_exp     = exps;
    pix_word_in = word;
    pix_valid   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pix_ready && n < 100);
    checks++;
    if (!pix_ready) begin
      errors++;
      $display("[TB] FAIL handshake_timeout: got pix_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic run_row(input int stall, input bit glitch);
    int n;
    int done_before;
    gaps.delete();
    max_run     = 0;
    done_before = rows_done;
    row_start   = 1'b1;
    @(posedge clk);
    #1;
    row_start = 1'b0;
    for (int w = 0; w < WPR; w++) begin
      if (w > 0 && stall > 0) begin
        n = 0;
        for (int c = 0; c < 200 && n < stall; c++) begin
          @(negedge clk);
          if (pix_ready) n++;
          @(posedge clk);
          #1;
        end
      end
      apply_stimulus(row_words[w], row_exps[w]);
      if (w == 0 && glitch) begin
        row_start = 1'b1;
        @(posedge clk);
        #1;
        row_start = 1'b0;
      end
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!row_done && n < 200);
    checks++;
    if (!row_done) begin
      errors++;
      $display("[TB] FAIL row_done_timeout: got row_done=0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    check_output("busy_after_done", busy, 0);
    check_output("rows_done", rows_done - done_before, 1);
    if (stall > 0) begin
      check_output("stall_gap_count", gaps.size(), 1);
      if (gaps.size() > 0) check_output("stall_gap_len", gaps[0], stall);
    end else begin
      check_output("run_len", max_run, WIN_WIDTH + DESC_DIM - 1);
      check_output("gap_count", gaps.size(), 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_window_out"}, window_out, 0);
    check_output({tag, "_load_win"}, load_win_reg, 0);
    check_output({tag, "_load_acc"}, load_acc_sum_reg, 0);
    check_output({tag, "_row_done"}, row_done, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_pix_ready"}, pix_ready, 0);
  endtask

  initial begin
    int saw_done;
    rst         = 1'b1;
    row_start   = 1'b0;
    pix_valid   = 1'b0;
    pix_word_in = '0;
    cur_exp     = '0;
    rows_done   = 0;
    max_run     = 0;
`ifdef NCC_FEEDER_MEAN_SUB_EN
    mean_in     = 8'd0;
`endif
    vecs[0] = mk_vec(32'h01030AC8, 33'h000000000, 33'h00C000000, 33'h01A000000, 33'h03C800000);
    vecs[1] = mk_vec(32'hFF000102, 33'h03FF00000, 33'h000000000, 33'h000000000, 33'h008000000);
    vecs[2] = mk_vec(32'h80402010, 33'h038000000, 33'h030000000, 33'h028000000, 33'h020000000);
    vecs[3] = mk_vec(32'h7F050604, 33'h037E00000, 33'h012000000, 33'h014000000, 33'h010000000);

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("idle");

    $display("[TB] table rows (second row stalled for 5 cycles)");
    for (int r = 0; r < 2; r++) begin
      for (int w = 0; w < WPR; w++) begin
        row_words[w] = vecs[r*WPR + w].word;
        row_exps[w]  = vecs[r*WPR + w].exp;
      end
      run_row((r == 1) ? 5 : 0, 1'b0);
    end

    $display("[TB] row_start pulsed during EMIT");
    for (int w = 0; w < WPR; w++) begin
      row_words[w] = vecs[w].word;
      row_exps[w]  = vecs[w].exp;
    end
    run_row(0, 1'b1);

    $display("[TB] randomized rows");
    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < WPR; w++) begin
        row_words[w] = $urandom();
        row_exps[w]  = model_word(row_words[w], 0);
      end
      run_row(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0, 1'b0);
    end

    $display("[TB] reset during second flush cycle");
    row_start = 1'b1;
    @(posedge clk);
    #1;
    row_start = 1'b0;
    for (int w = 0; w < WPR; w++) apply_stimulus(vecs[2+w].word, vecs[2+w].exp);
    repeat (5) @(posedge clk);
    #1;
    check_output("flush2_load", load_win_reg, 1);
    check_output("flush2_window", window_out, 0);
    check_output("flush2_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("flush_reset");
    rst = 1'b0;
    saw_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (row_done) saw_done = 1;
    end
    check_output("no_row_done_after_reset", saw_done, 0);
    check_output("idle_after_reset", busy, 0);

    for (int w = 0; w < WPR; w++) begin
      row_words[w] = $urandom();
      row_exps[w]  = model_word(row_words[w], 0);
    end
    run_row(0, 1'b0);

`ifdef NCC_FEEDER_MEAN_SUB_EN
    $display("[TB] mean subtraction, mean_in=100");
    mean_in      = 8'd100;
    row_words[0] = 32'h6463E400;
    row_exps[0]  = model_word(row_words[0], 100);
    for (int w = 1; w < WPR; w++) begin
      row_words[w] = $urandom();
      row_exps[w]  = model_word(row_words[w], 100);
    end
    run_row(0, 1'b0);
    mean_in = 8'd0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
